// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-side controller of the async FIFO (RAM write port, Gray pointers, full/count/overflow).
// Define AFIFO_WR_ALMOST_FULL_EN to add the registered wr_almost_full flag.
module afifo_wr_ctrl #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
`ifdef AFIFO_WR_ALMOST_FULL_EN
   , parameter int AFULL_THRESH = 2
`endif
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic [DATASIZE-1:0] idata,
   input  logic                wren,
   output logic                wr_full,
   input  logic [ADDRSIZE:0]   rptr_gray_in,
   output logic [ADDRSIZE:0]   wptr_gray,
   output logic                mem_wen,
   output logic [ADDRSIZE-1:0] mem_waddr,
   output logic [DATASIZE-1:0] mem_wdata,
   output logic [ADDRSIZE:0]   wr_count,
   output logic                wr_overflow
`ifdef AFIFO_WR_ALMOST_FULL_EN
   , output logic              wr_almost_full
`endif
);
   typedef logic [ADDRSIZE:0] ptr_t;
   ptr_t wbin_q, wbin_d, wgray_q, wgray_d, rq1_q, rq2_q, rbin, count_q, count_d;
   logic full_q, full_d, ovf_q, ovf_d, accept;
   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_rbin
      assign rbin[i] = ^(rq2_q >> i);
   end
   always_comb begin
      accept  = wren & ~full_q;
      wbin_d  = wbin_q + ptr_t'(accept);
      wgray_d = wbin_d ^ (wbin_d >> 1);
      count_d = wbin_d - rbin;
      full_d  = wgray_d == {~rq2_q[ADDRSIZE:ADDRSIZE-1], rq2_q[ADDRSIZE-2:0]};
      ovf_d   = wren & full_q;
   end
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         rq1_q   <= '0;
         rq2_q   <= '0;
         full_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         rq1_q   <= rptr_gray_in;
         rq2_q   <= rq1_q;
         full_q  <= full_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end
   assign mem_wen     = accept;
   assign mem_waddr   = wbin_q[ADDRSIZE-1:0];
   assign mem_wdata   = idata;
   assign wptr_gray   = wgray_q;
   assign wr_full     = full_q;
   assign wr_count    = count_q;
   assign wr_overflow = ovf_q;
`ifdef AFIFO_WR_ALMOST_FULL_EN
   localparam ptr_t AF_LVL = ptr_t'((1 << ADDRSIZE) - AFULL_THRESH);
   logic afull_q;
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) afull_q <= 1'b0;
      else afull_q <= count_d >= AF_LVL;
   end
   assign wr_almost_full = afull_q;
`endif
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb_afifo_wr_ctrl: scoreboard bench for afifo_wr_ctrl (fill, overflow, release, wrap, reset, optional almost-full).
module tb_afifo_wr_ctrl;
   logic       wclk = 1'b0, wrst = 1'b1, wren = 1'b0;
   logic [7:0] idata = '0, mem_wdata;
   logic [4:0] rptr_gray_in = '0, wptr_gray, wr_count;
   logic [3:0] mem_waddr;
   logic       wr_full, mem_wen, wr_overflow;
`ifdef AFIFO_WR_ALMOST_FULL_EN
   logic       wr_almost_full;
`endif
   int errs = 0, checks = 0;
   logic [11:0] sb[$];
   logic [4:0] wp, s1, s2, e_cnt;
   logic       e_full, e_ovf, e_af;
   afifo_wr_ctrl dut (
      .wclk(wclk), .wrst(wrst), .idata(idata), .wren(wren), .wr_full(wr_full),
      .rptr_gray_in(rptr_gray_in), .wptr_gray(wptr_gray), .mem_wen(mem_wen),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wr_count(wr_count),
      .wr_overflow(wr_overflow)
`ifdef AFIFO_WR_ALMOST_FULL_EN
      , .wr_almost_full(wr_almost_full)
`endif
   );
   always #5 wclk = ~wclk;
   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [4:0] gb(input logic [4:0] gr);
      logic [4:0] b;
      b[4] = gr[4];
      for (int k = 3; k >= 0; k--) b[k] = b[k+1] ^ gr[k];
      return b;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic mreset();
      wp = '0; s1 = '0; s2 = '0; e_cnt = '0;
      e_full = 1'b0; e_ovf = 1'b0; e_af = 1'b0;
      sb.delete();
   endtask
   // one wclk cycle: drive, push expectation, compare RAM port, advance model, compare registers
   task automatic cyc(input logic we, input logic [7:0] d);
      logic acc;
      logic [4:0] wn, occ;
      logic [11:0] e;
      wren = we; idata = d;
      #1;
      acc = we && !e_full;
      if (acc) sb.push_back({wp[3:0], d});
      check("mem_wen", mem_wen, acc);
      if (mem_wen) begin
         check("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("mem_waddr", mem_waddr, e[11:8]);
            check("mem_wdata", mem_wdata, e[7:0]);
         end
      end
      wn = wp + 5'(acc);
      occ = wn - gb(s2);
      e_ovf = we && e_full;
      e_full = occ == 5'd16;
      e_cnt = occ;
      e_af = occ >= 5'd14;
      s2 = s1; s1 = rptr_gray_in; wp = wn;
      @(posedge wclk);
      #1;
      check("wr_full", wr_full, e_full);
      check("wr_count", wr_count, e_cnt);
      check("wr_overflow", wr_overflow, e_ovf);
      check("wptr_gray", wptr_gray, g(wp));
`ifdef AFIFO_WR_ALMOST_FULL_EN
      check("wr_almost_full", wr_almost_full, e_af);
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
   initial begin
      int rel;
      logic saw, anyfull;
      logic [4:0] prev;
      mreset();
      repeat (2) @(posedge wclk);
      #1;
      check("rst_full", wr_full, 0);
      check("rst_gray", wptr_gray, 0);
      check("rst_count", wr_count, 0);
      check("rst_ovf", wr_overflow, 0);
      check("rst_waddr", mem_waddr, 0);
      wrst = 1'b0;
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i));
      check("fill_full", wr_full, 1);
      check("fill_gray", wptr_gray, 5'b11000);
      check("fill_count", wr_count, 16);
      cyc(1'b1, 8'hAA);
      check("ovf_gray", wptr_gray, 5'b11000);
      check("ovf_pulse", wr_overflow, 1);
      cyc(1'b0, 8'h00);
      check("ovf_clear", wr_overflow, 0);
      rptr_gray_in = 5'b00001;
      rel = 0;
      for (int n = 1; n <= 6; n++) begin
         cyc(1'b0, 8'h00);
         if (!wr_full && rel == 0) rel = n;
      end
      check("release_edges", rel, 3);
      check("release_count", wr_count, 15);
      // asynchronous reset mid-cycle, away from any edge
      cyc(1'b1, 8'h55);
      wren = 1'b0; rptr_gray_in = '0;
      @(negedge wclk);
      wrst = 1'b1;
      #1;
      check("arst_full", wr_full, 0);
      check("arst_gray", wptr_gray, 0);
      check("arst_count", wr_count, 0);
      check("arst_ovf", wr_overflow, 0);
      check("arst_wen", mem_wen, 0);
      check("arst_waddr", mem_waddr, 0);
      mreset();
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      saw = 1'b0; anyfull = 1'b0;
      for (int i = 0; i < 40; i++) begin
         prev = wptr_gray;
         cyc(1'b1, 8'(8'h80 + i));
         rptr_gray_in = g(wp);
         if (prev == 5'b10000 && wptr_gray == 5'b00000) saw = 1'b1;
         if (wr_full) anyfull = 1'b1;
      end
      check("wrap_seen", saw, 1);
      check("wrap_nofull", anyfull, 0);
`ifdef AFIFO_WR_ALMOST_FULL_EN
      wren = 1'b0; rptr_gray_in = '0;
      @(negedge wclk);
      wrst = 1'b1;
      mreset();
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      for (int i = 0; i < 13; i++) cyc(1'b1, 8'(i));
      check("af_13", wr_almost_full, 0);
      cyc(1'b1, 8'h0D);
      check("af_14", wr_almost_full, 1);
      rptr_gray_in = g(5'd3);
      rel = 0;
      for (int n = 1; n <= 6; n++) begin
         cyc(1'b0, 8'h00);
         if (!wr_almost_full && rel == 0) rel = n;
      end
      check("af_release_edges", rel, 3);
`endif
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/afifo_wr_ctrl.md
# afifo_wr_ctrl

Write-domain controller of the asynchronous FIFO: the responder on the write-side interface (`idata`, `wren`, `wr_full`). It accepts write requests in the `wclk` domain, drives the write port of the dual-port FIFO RAM, and maintains binary and Gray write pointers. It synchronises the read-domain Gray pointer and produces a registered full flag, an occupancy estimate and an overflow pulse.

## Interface

Parameters:
- `DATASIZE`, default 8 (package value): data word width.
- `ADDRSIZE`, default 4: RAM address width. Depth = 2^ADDRSIZE = 16.
- `AFULL_THRESH`, default 2: free-slot margin for almost-full. Used only when the macro is defined.

Ports:
- `wclk`  in  1  write clock.
- `wrst`  in  1  reset, asynchronous, active-high.
- `idata`  in  DATASIZE  write data.
- `wren`  in  1  write request.
- `wr_full`  out  1  FIFO full (registered).
- `rptr_gray_in`  in  ADDRSIZE+1  read pointer, Gray coded, asynchronous to `wclk`.
- `wptr_gray`  out  ADDRSIZE+1  write pointer, Gray coded, registered, sent to the read domain.
- `mem_wen`  out  1  RAM write enable.
- `mem_waddr`  out  ADDRSIZE  RAM write address.
- `mem_wdata`  out  DATASIZE  RAM write data.
- `wr_count`  out  ADDRSIZE+1  occupancy as seen by the write side (registered).
- `wr_overflow`  out  1  one-cycle pulse when a write is rejected.
- `wr_almost_full`  out  1  almost-full flag. Present only with the macro.

## Operation

- **Accept:** `accept = wren & ~wr_full`.
  - `mem_wen = accept` (combinational).
  - `mem_waddr = wbin[ADDRSIZE-1:0]`.
  - `mem_wdata = idata`.
  - The RAM captures the word on the same `wclk` edge.
- **Pointers:**
  - `wbin_next = wbin + accept`, modulo 2^(ADDRSIZE+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
  - `wbin` and `wptr_gray` are registered from these values.
  - The pointer wraps 31 -> 0 naturally.
- **Synchroniser:** `rptr_gray_in` passes through two flops, `rq1` then `rq2`. No other logic touches the unsynchronised value.
- **Full:** `wr_full <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]})`.
- **Count:** `wr_count <= wbin_next - gray2bin(rq2)`, computed modulo 2^(ADDRSIZE+1). Range 0..16.
- **Overflow:** `wr_overflow <= wren & wr_full`. The rejected write is dropped, and the pointer and RAM are unchanged.
- **Reset:** asynchronous clear of all outputs and state to 0: `wbin`, `wptr_gray`, `rq1`, `rq2`, `wr_full`, `wr_count`, `wr_overflow`, `wr_almost_full`.
  - Combinational outputs follow: `mem_wen` = 0, `mem_waddr` = 0.
  - Reset mid-fill discards all contents. The read domain must be reset concurrently; this block does not enforce that.

## Timing

- Write latency: a word accepted at edge n is in the RAM after edge n.
- `wptr_gray` updates at edge n.
- Full assertion: `wr_full` rises at the same edge that accepts the 16th outstanding word. A `wren` in the next cycle is rejected.
- Full deassertion is pessimistic. A read-pointer change stable before edge k gives:
  - `rq1` at edge k,
  - `rq2` at edge k+1,
  - `wr_full` and `wr_count` at edge k+2.
- Simultaneous `wren` and a read-pointer change: `wr_full` is evaluated on the new `wbin_next` against the old `rq2`, so it may stay set for one extra cycle. This is never unsafe.
- `wptr_gray` changes by at most one bit per `wclk` edge.
- `wr_overflow` is high for exactly one cycle per rejected `wren` cycle.

## Configuration

- Macro: `AFIFO_WR_ALMOST_FULL_EN`.
- **Defined:**
  - The `wr_almost_full` port exists.
  - `wr_almost_full <= (wbin_next - gray2bin(rq2)) >= 2^ADDRSIZE - AFULL_THRESH`, registered. It is 1 at count >= 14 with defaults.
  - Reset value 0.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan

- **Reset:** assert `wrst` mid-cycle. Outputs go to 0 immediately without a clock edge: `wr_full`, `wptr_gray`, `wr_count`, `wr_overflow`, `mem_wen`, `mem_waddr`.
- **Fill:** hold `rptr_gray_in` = 0 and issue 16 consecutive writes of 0x00..0x0F.
  - `mem_waddr` runs 0..15.
  - `wr_full` = 1 after the 16th edge.
  - `wptr_gray` = 5'b11000.
  - `wr_count` = 16.
- **Overflow:** when full, write 0xAA.
  - `mem_wen` = 0.
  - `wr_overflow` pulses for 1 cycle.
  - `wptr_gray` stays 5'b11000.
- **Drain release:** when full, set `rptr_gray_in` = 5'b00001. `wr_full` falls exactly 3 edges later and `wr_count` = 15.
- **Wrap:** with `rptr_gray_in` tracking writes, issue 40 writes.
  - `wptr_gray` passes from 5'b10000 (ptr 31) to 5'b00000.
  - `mem_waddr` wraps 15 -> 0.
  - There is no spurious `wr_full`.
- **Almost-full (macro defined, AFULL_THRESH = 2):** with `rptr_gray_in` = 0, `wr_almost_full` rises after the 14th write. Setting `rptr_gray_in` = gray(3) clears it 3 edges later.
